// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Multi-cycle controller in front of the calculator's 8-bit signed ALU.
//   It accepts one request at a time while idle and returns a registered
//   16-bit result with overflow/error status. ADD/SUB/MUL/DIV/illegal complete
//   on the accept edge. EXP performs one multiply per cycle and exits early on
//   16-bit overflow.
//
//   Optional feature: define CALC_OP_COUNT_EN to add the op_count output. It
//   is a wrapping completion counter that steps on every DONE cycle.
//
// Ports
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high reset
//   start    : request strobe, sampled only while idle
//   op       : 0=ADD 1=SUB 2=MUL 3=DIV 4=EXP, 5-7 illegal
//   a, b     : signed 8-bit operands
//   busy     : high whenever not idle
//   done     : one-cycle completion pulse
//   result   : signed 16-bit result, held until the next accepted start
//   ovf      : overflow status, held with result
//   err      : error status (illegal op, divide by zero, bad exponent)
//   op_count : completion counter (only with CALC_OP_COUNT_EN)

module alu_op_sequencer #(
    parameter int MAX_EXP = 127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic        err
`ifdef CALC_OP_COUNT_EN
    ,
    output logic [15:0] op_count
`endif
);

    typedef enum logic [1:0] {IDLE, EXP_LOOP, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_EXP = 3'd4
    } op_t;

    state_t      state, state_next;
    logic [15:0] result_next;
    logic        ovf_next, err_next;
    logic [15:0] acc, acc_next;
    logic [7:0]  cnt, cnt_next;
    logic [7:0]  base, base_next;

    op_t                op_code;
    logic signed [15:0] a_ext, b_ext;
    logic signed [7:0]  quot, rem;
    logic        [23:0] prod;
    logic               prod_ovf;

    assign op_code = op_t'(op);
    assign a_ext   = {{8{a[7]}}, a};
    assign b_ext   = {{8{b[7]}}, b};

    // Divide by zero and -128/-1 are handled separately, so keep the divider
    // away from those operand pairs. The signed zero keeps the whole
    // expression in signed context.
    assign quot = (b == 8'h00 || (a == 8'h80 && b == 8'hFF)) ? 8'sd0
                : $signed(a) / $signed(b);
    assign rem  = (b == 8'h00 || (a == 8'h80 && b == 8'hFF)) ? 8'sd0
                : $signed(a) % $signed(b);

    // The product of sign-extended operands has the same low 24 bits in signed
    // and unsigned arithmetic. It fits in 16 bits only if bits 23:15 agree.
    assign prod     = {{8{acc[15]}}, acc} * {{16{base[7]}}, base};
    assign prod_ovf = !((prod[23:15] == '0) || (prod[23:15] == '1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_next  = state;
        result_next = result;
        ovf_next    = ovf;
        err_next    = err;
        acc_next    = acc;
        cnt_next    = cnt;
        base_next   = base;

        case (state)
            IDLE: begin
                if (start) begin
                    result_next = '0;
                    ovf_next    = 1'b0;
                    err_next    = 1'b0;
                    base_next   = a;
                    state_next  = DONE;
                    case (op_code)
                        OP_ADD: result_next = a_ext + b_ext;
                        OP_SUB: result_next = a_ext - b_ext;
                        OP_MUL: result_next = a_ext * b_ext;
                        OP_DIV: begin
                            if (b == 8'h00) begin
                                err_next = 1'b1;
                            end else if (a == 8'h80 && b == 8'hFF) begin
                                ovf_next    = 1'b1;
                                result_next = 16'h8000;
                            end else begin
                                result_next = {quot, rem};
                            end
                        end
                        OP_EXP: begin
                            if (b[7] || (int'($signed(b)) > MAX_EXP)) begin
                                err_next = 1'b1;
                            end else if (b == 8'h00) begin
                                result_next = 16'd1;
                            end else begin
                                acc_next   = 16'd1;
                                cnt_next   = b;
                                state_next = EXP_LOOP;
                            end
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end
            EXP_LOOP: begin
                if (prod_ovf) begin
                    ovf_next    = 1'b1;
                    result_next = '0;
                    state_next  = DONE;
                end else begin
                    acc_next = prod[15:0];
                    cnt_next = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        result_next = prod[15:0];
                        state_next  = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            base   <= '0;
        end else begin
            state  <= state_next;
            result <= result_next;
            ovf    <= ovf_next;
            err    <= err_next;
            acc    <= acc_next;
            cnt    <= cnt_next;
            base   <= base_next;
        end
    end

`ifdef CALC_OP_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (state == DONE) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer.
// Each request's final result, status and latency come from the arithmetic
// rules in model_op. A cycle-level countdown then derives the expected
// busy/done/result/ovf/err for every cycle. The directed cases pin both the
// model and the DUT with hand-computed literals.

module tb_alu_op_sequencer;

    localparam int MAX_EXP = 127;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic        err;
`ifdef CALC_OP_COUNT_EN
    logic [15:0] op_count;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: m_rem counts the remaining busy cycles, with 1 meaning done.
    int          m_rem = 0;
    logic [15:0] m_res = '0;
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] p_res = '0;
    logic        p_ovf = 1'b0;
    logic        p_err = 1'b0;
    logic [15:0] m_cnt = '0;

    alu_op_sequencer #(.MAX_EXP(MAX_EXP)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .err    (err)
`ifdef CALC_OP_COUNT_EN
        ,
        .op_count (op_count)
`endif
    );

    always #5 clk = ~clk;

    // Final result/status and the number of edges after the accept edge
    // until DONE is entered.
    function automatic void model_op(input logic [2:0] o, input logic [7:0] x, y,
                                     output logic [15:0] r, output logic ov, er,
                                     output int edges);
        int sa, sb, acc, p, q, rm;
        sa = int'($signed(x));
        sb = int'($signed(y));
        r = '0; ov = 1'b0; er = 1'b0; edges = 0;
        case (o)
            3'd0: r = 16'(sa + sb);
            3'd1: r = 16'(sa - sb);
            3'd2: r = 16'(sa * sb);
            3'd3: begin
                if (sb == 0) er = 1'b1;
                else if (sa == -128 && sb == -1) begin ov = 1'b1; r = 16'h8000; end
                else begin
                    q = sa / sb; rm = sa % sb;
                    r = {8'(q), 8'(rm)};
                end
            end
            3'd4: begin
                if (sb < 0 || sb > MAX_EXP) er = 1'b1;
                else if (sb == 0) r = 16'd1;
                else begin
                    acc = 1;
                    edges = sb;
                    for (int i = 1; i <= sb; i++) begin
                        p = acc * sa;
                        if (p > 32767 || p < -32768) begin
                            ov = 1'b1; edges = i; break;
                        end
                        acc = p;
                    end
                    if (!ov) r = 16'(acc);
                end
            end
            default: er = 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [15:0] fr;
        logic        fo, fe;
        int          fed;
        if (reset) begin
            m_rem <= 0;
            m_res <= '0; m_ovf <= 1'b0; m_err <= 1'b0;
            m_cnt <= '0;
        end else begin
            if (m_rem == 1) m_cnt <= m_cnt + 16'd1;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 2) begin
                    m_res <= p_res; m_ovf <= p_ovf; m_err <= p_err;
                end
            end else if (start) begin
                model_op(op, a, b, fr, fo, fe, fed);
                m_rem <= fed + 1;
                if (fed == 0) begin
                    m_res <= fr; m_ovf <= fo; m_err <= fe;
                end else begin
                    m_res <= '0; m_ovf <= 1'b0; m_err <= 1'b0;
                    p_res <= fr; p_ovf <= fo; p_err <= fe;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy",   32'(busy),   32'(m_rem != 0));
            check("cyc done",   32'(done),   32'(m_rem == 1));
            check("cyc result", 32'(result), 32'(m_res));
            check("cyc ovf",    32'(ovf),    32'(m_ovf));
            check("cyc err",    32'(err),    32'(m_err));
`ifdef CALC_OP_COUNT_EN
            check("cyc op_count", 32'(op_count), 32'(m_cnt));
`endif
        end
    end

    // Issue one request once idle. Report the edges from the accept edge to
    // done, and the outputs seen in the done cycle. With hold set, start stays
    // high with different operands until done.
    task automatic issue(input logic [2:0] o, input logic [7:0] x, y, input bit hold,
                         output int edges, output logic [15:0] r, output logic ov, er);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy === 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        if (hold) begin
            op = 3'd0; a = 8'd1; b = 8'd1;
        end else begin
            start = 1'b0;
        end
        edges = 0;
        while (done !== 1'b1 && edges < 300) begin
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL done timeout: got no done want done within 300 cycles");
        end
        r = result; ov = ovf; er = err;
    endtask

    task automatic directed(input string name, input logic [2:0] o, input int x, y,
                            input logic [15:0] xr, input logic xo, xe,
                            input int xedges, input bit hold);
        int          ed;
        logic [15:0] r;
        logic        ov, er;
        issue(o, 8'(x), 8'(y), hold, ed, r, ov, er);
        check({name, " result"}, 32'(r),  32'(xr));
        check({name, " ovf"},    32'(ov), 32'(xo));
        check({name, " err"},    32'(er), 32'(xe));
        check({name, " edges"},  32'(ed), 32'(xedges));
    endtask

    task automatic pin_model(input string name, input logic [2:0] o, input int x, y,
                             input logic [15:0] xr, input logic xo, xe, input int xedges);
        logic [15:0] r;
        logic        ov, er;
        int          ed;
        model_op(o, 8'(x), 8'(y), r, ov, er, ed);
        check({name, " model"}, {r, 7'd0, ov, 7'd0, er}, {xr, 7'd0, xo, 7'd0, xe});
        check({name, " model edges"}, 32'(ed), 32'(xedges));
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout: got no finish want finish by 2ms");
        $fatal(1, "global timeout");
    end

    initial begin
        int          ed;
        logic [15:0] r;
        logic        ov, er;
        int          pick, x, y;
        logic [2:0]  o;
        bit          hold;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b0;
        check("reset busy",   32'(busy),   32'd0);
        check("reset done",   32'(done),   32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset ovf",    32'(ovf),    32'd0);
        check("reset err",    32'(err),    32'd0);

        pin_model("exp3^5", 3'd4, 3, 5, 16'h00F3, 1'b0, 1'b0, 5);
        pin_model("div-7/2", 3'd3, -7, 2, 16'hFDFF, 1'b0, 1'b0, 0);
        pin_model("exp2^15", 3'd4, 2, 15, 16'h0000, 1'b1, 1'b0, 15);

        directed("add",      3'd0,  100,  100, 16'h00C8, 1'b0, 1'b0, 0,  1'b0);
        directed("sub",      3'd1, -128,  127, 16'hFF01, 1'b0, 1'b0, 0,  1'b0);
        directed("mul",      3'd2, -128, -128, 16'h4000, 1'b0, 1'b0, 0,  1'b0);
        directed("div",      3'd3,   -7,    2, 16'hFDFF, 1'b0, 1'b0, 0,  1'b0);
        directed("div0",     3'd3,    5,    0, 16'h0000, 1'b0, 1'b1, 0,  1'b0);
        directed("divovf",   3'd3, -128,   -1, 16'h8000, 1'b1, 1'b0, 0,  1'b0);
        directed("exp3_5",   3'd4,    3,    5, 16'h00F3, 1'b0, 1'b0, 5,  1'b0);
        directed("expm2_15", 3'd4,   -2,   15, 16'h8000, 1'b0, 1'b0, 15, 1'b0);
        directed("exp2_15",  3'd4,    2,   15, 16'h0000, 1'b1, 1'b0, 15, 1'b0);
        directed("expneg",   3'd4,    5,   -1, 16'h0000, 1'b0, 1'b1, 0,  1'b0);
        directed("exp0",     3'd4,    7,    0, 16'h0001, 1'b0, 1'b0, 0,  1'b0);
        directed("illegal",  3'd6,    1,    2, 16'h0000, 1'b0, 1'b1, 0,  1'b0);
        directed("exphold",  3'd4,    2,    6, 16'h0040, 1'b0, 1'b0, 6,  1'b1);
        directed("addafter", 3'd0,    1,    2, 16'h0003, 1'b0, 1'b0, 0,  1'b0);

        // Reset in the third EXP_LOOP cycle.
        @(negedge clk);
        while (busy === 1'b1) @(negedge clk);
        start = 1'b1; op = 3'd4; a = 8'd2; b = 8'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy",   32'(busy),   32'd0);
        check("midreset result", 32'(result), 32'd0);
        check("midreset done",   32'(done),   32'd0);
`ifdef CALC_OP_COUNT_EN
        check("midreset op_count", 32'(op_count), 32'd0);
`endif
        repeat (8) begin
            @(negedge clk);
            check("no done after reset", 32'(done), 32'd0);
        end
        directed("cnt1", 3'd0, 1, 1, 16'h0002, 1'b0, 1'b0, 0, 1'b0);
        directed("cnt2", 3'd3, 1, 0, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        directed("cnt3", 3'd4, 2, 1, 16'h0002, 1'b0, 1'b0, 1, 1'b0);
        @(negedge clk);
`ifdef CALC_OP_COUNT_EN
        check("op_count 3", 32'(op_count), 32'd3);
`endif

        for (int n = 0; n < 250; n++) begin
            pick = int'($urandom_range(0, 9));
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            if (pick < 4) begin
                o = 3'(pick);
                if (pick == 3 && $urandom_range(0, 5) == 0) y = 0;
            end else if (pick < 8) begin
                o = 3'd4;
                x = int'($urandom_range(0, 8)) - 4;
                y = int'($urandom_range(0, 22)) - 2;
                if ($urandom_range(0, 9) == 0) x = int'($urandom_range(0, 255));
            end else begin
                o = 3'(5 + $urandom_range(0, 2));
            end
            hold = ($urandom_range(0, 9) == 0);
            issue(o, 8'(x), 8'(y), hold, ed, r, ov, er);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
